pipe_stall_ctrl: RTL
====================

# pipe_stall_ctrl

Pipeline stall controller and multi-cycle EX sequencer for the five-stage core. It merges stall requests from ID and EX into the 6-bit `stall` vector consumed by PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also sequences the two-phase MADD/MADDU/MSUB/MSUBU operations and the handshake with the iterative divider. It replaces the ad-hoc count loopback through EX/MEM with an explicit phase output.

## Interface
- `DIV_TIMEOUT`, default 40: maximum cycles spent in DIV_WAIT before abort; legal range 2..255.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `stallreq_id`  in  1  ID hazard request (load-use, branch operand), same-cycle.
- `stallreq_ex`  in  1  generic EX stall request, same-cycle.
- `mac_op`  in  1  EX holds a MADD/MADDU/MSUB/MSUBU.
- `div_op`  in  1  EX holds a DIV/DIVU.
- `div_done`  in  1  divider result valid, one-cycle pulse.
- `stall`  out  6  bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB; 1 = hold.
- `mac_cnt`  out  2  MAC phase to EX: 00 = product phase, 01 = accumulate phase.
- `div_start`  out  1  one-cycle start pulse to the divider.
- `div_abort`  out  1  one-cycle pulse; timeout abandoned the divide.
- `div_timeout_err`  out  1  sticky flag; set on any abort, cleared only by `rst`.
- `busy`  out  1  sequencer not in IDLE.

## Operation
- State register with three states: IDLE, MAC, DIV_WAIT. The 8-bit counter `div_cnt` is internal.
- `seq_stall` is the internal EX-level stall from the sequencer.
- `stall` encoding:
  - `seq_stall` or `stallreq_ex` gives 6'b001111.
  - Otherwise, `stallreq_id` gives 6'b000111.
  - Otherwise, 6'b000000.
  - Bits 4 and 5 are never asserted by this block.
- IDLE:
  - `div_op` has priority over `mac_op`.
  - `div_op`: `div_start` = 1 and `seq_stall` = 1; go to DIV_WAIT and clear `div_cnt`.
  - `mac_op` (no `div_op`): `mac_cnt` = 00 and `seq_stall` = 1; go to MAC.
  - Neither: `mac_cnt` = 00, no sequencer stall.
- MAC:
  - `mac_cnt` = 01, `seq_stall` = 0.
  - `mac_op` is ignored, because it is the same instruction.
  - If `stallreq_ex` = 0, go to IDLE. Otherwise stay in MAC with `mac_cnt` held at 01.
- DIV_WAIT:
  - `seq_stall` = 1 unless `div_done` = 1 or a timeout occurs.
  - `div_done` = 1: `seq_stall` = 0 in the same cycle, go to IDLE.
  - If `stallreq_ex` is also high, `stall` stays at 001111 and the EX/MEM capture waits. EX must hold the divider result; this is outside this block's scope.
  - No done and `div_cnt` == `DIV_TIMEOUT`-1: `div_abort` = 1, `seq_stall` = 0, `div_timeout_err` <= 1, go to IDLE.
  - Otherwise `div_cnt` increments.
  - `div_start` is never asserted outside IDLE.
- Back-to-back: a new `div_op` or `mac_op` seen in IDLE on the cycle after return starts a new sequence. This is correct, because the previous instruction left EX at the releasing edge.
- `div_done` seen in IDLE or MAC is ignored. It has no effect on `div_timeout_err`.

## Timing
- `stall`, `div_start`, `div_abort` and `mac_cnt` are combinational from the state and the current-cycle inputs. They have zero latency relative to the requests.
- State, `div_cnt` and `div_timeout_err` update on `posedge clk`.
- MAC with no other stalls: exactly 2 cycles in EX.
  - Cycle 1: `stall` = 001111, `mac_cnt` = 00.
  - Cycle 2: `stall` = 0, `mac_cnt` = 01.
- DIV: the start cycle plus N wait cycles, where `div_done` arrives in wait cycle N. `stall` is low in wait cycle N only.
- Timeout:
  - The abort fires in wait cycle `DIV_TIMEOUT`.
  - The stall lasts `DIV_TIMEOUT` cycles in total: the start cycle plus `DIV_TIMEOUT`-1 wait cycles.
- Reset behaviour:
  - While `rst` = 1: all outputs are 0 and the next state is IDLE, with `div_cnt` = 0 and `div_timeout_err` = 0.
  - Reset mid-MAC or mid-DIV abandons the sequence without pulsing `div_abort`.
  - The first cycle after reset is IDLE.

## Test plan
- Reset: assert `rst` in DIV_WAIT with `div_cnt` = 10 -> next cycle `stall` = 0, `busy` = 0, `div_timeout_err` = 0. With `rst` low, `div_op` = 1 -> `div_start` = 1.
- Priority: `stallreq_id` = 1 alone -> `stall` = 000111. Then `stallreq_id` = `stallreq_ex` = 1 -> `stall` = 001111. Then both 0 -> 000000.
- MAC: `mac_op` = 1 for 2 cycles -> `stall`/`mac_cnt` = 001111/00, then 000000/01, then IDLE. Repeat with `stallreq_ex` = 1 during cycle 2 for 3 cycles -> `mac_cnt` stays 01 for 4 cycles total, `stall` = 001111 for 3 of them.
- DIV normal: `div_op` = 1, `div_done` pulsed in wait cycle 33 -> `div_start` is high for 1 cycle only, `stall` = 001111 for 33 cycles, low in the done cycle, `div_abort` never asserted.
- DIV timeout with `DIV_TIMEOUT` = 40 and no `div_done` -> `div_abort` pulses in wait cycle 40, `stall` drops in that same cycle, `div_timeout_err` = 1 afterwards. A following DIV completes normally and `div_timeout_err` stays 1.
- Back-to-back DIV, then MAC with `div_op` held for the second instruction -> the second `div_start` occurs exactly 1 cycle after the first `div_done`. A `div_op` and `mac_op` asserted together -> the DIV path is taken.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall merger and two-phase MAC / iterative-divide sequencer for EX.
// Latency: stall, mac_cnt, div_start, div_abort are combinational (zero cycles); state updates on posedge clk.
// Backpressure: a generic EX stall holds MAC in its accumulate phase; the divide wait ends on div_done or timeout.
module pipe_stall_ctrl #(
    parameter int DIV_TIMEOUT = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stallreq_id,
    input  logic       stallreq_ex,
    input  logic       mac_op,
    input  logic       div_op,
    input  logic       div_done,
    output logic [5:0] stall,
    output logic [1:0] mac_cnt,
    output logic       div_start,
    output logic       div_abort,
    output logic       div_timeout_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MAC      = 2'd1,
        DIV_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DIV_TIMEOUT - 1);

    state_t     state;
    logic [7:0] div_cnt;
    logic       err_q;

    logic       seq_stall;
    logic       start_c;
    logic       abort_c;
    logic       mac_ph;
    logic       timeout_hit;

    assign timeout_hit = (div_cnt == CNT_LAST);

    // Decode sequencer stall and per-cycle pulses from the current state and inputs.
    always_comb begin
        seq_stall = 1'b0;
        start_c   = 1'b0;
        abort_c   = 1'b0;
        mac_ph    = 1'b0;
        case (state)
            IDLE: begin
                if (div_op) begin
                    start_c   = 1'b1;
                    seq_stall = 1'b1;
                end else if (mac_op) begin
                    seq_stall = 1'b1;
                end
            end
            MAC: begin
                // mac_op here is the same instruction in its accumulate phase.
                mac_ph = 1'b1;
            end
            DIV_WAIT: begin
                if (div_done) begin
                    seq_stall = 1'b0;
                end else if (timeout_hit) begin
                    abort_c = 1'b1;
                end else begin
                    seq_stall = 1'b1;
                end
            end
            default: begin
                seq_stall = 1'b0;
            end
        endcase
    end

    // Merge stall sources into the per-stage hold vector; everything is forced low in reset.
    always_comb begin
        stall = 6'b000000;
        if (!rst) begin
            if (seq_stall || stallreq_ex) begin
                stall = 6'b001111;
            end else if (stallreq_id) begin
                stall = 6'b000111;
            end
        end
    end

    assign mac_cnt         = (!rst && mac_ph) ? 2'b01 : 2'b00;
    assign div_start       = !rst && start_c;
    assign div_abort       = !rst && abort_c;
    assign div_timeout_err = !rst && err_q;
    assign busy            = !rst && (state != IDLE);

    // Sequencer state, divide wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_op) begin
                        state   <= DIV_WAIT;
                        div_cnt <= 8'd0;
                    end else if (mac_op) begin
                        state <= MAC;
                    end
                end
                MAC: begin
                    if (!stallreq_ex) begin
                        state <= IDLE;
                    end
                end
                DIV_WAIT: begin
                    if (div_done) begin
                        state <= IDLE;
                    end else if (timeout_hit) begin
                        state <= IDLE;
                        err_q <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
